thirty_two_bit_fa: RTL and testbench

Registered 32-bit ripple-carry adder: computes `a + b + cin` through a chain of 32 one-bit full adders and captures the 33-bit result (`cout`, `sum`) on the rising clock edge. It is the basic arithmetic leaf for datapaths that need a simple, area-minimal adder with a carry-in/carry-out for cascading. It carries no control or handshake logic.

---
 rtl/thirty_two_bit_fa_pkg.sv | 6 +
 rtl/thirty_two_bit_fa_full_adder.sv | 16 +
 rtl/thirty_two_bit_fa.sv | 45 ++++
 tb/tb_thirty_two_bit_fa.sv | 106 ++++++++++
 4 files changed

// File: rtl/thirty_two_bit_fa_pkg.sv
// Shared constants for the registered ripple-carry adder.
package thirty_two_bit_fa_pkg;

    localparam int FA_WIDTH = 32;

endpackage

// File: rtl/thirty_two_bit_fa_full_adder.sv
// One-bit full adder: the single stage of the ripple-carry chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign sum  = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/thirty_two_bit_fa.sv
// Registered ripple-carry adder: {cout, sum} <= a + b + cin, one cycle latency.
module thirty_two_bit_fa
    import thirty_two_bit_fa_pkg::*;
#(
    parameter int WIDTH = FA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             cout,
    output logic [WIDTH-1:0] sum,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    assign c[0] = cin;

    // Carry ripples bit 0 -> bit WIDTH-1 through one full adder per bit.
    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_fa
            full_adder u_fa (
                .a    (a[i]),
                .b    (b[i]),
                .cin  (c[i]),
                .sum  (s[i]),
                .cout (c[i+1])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cout <= 1'b0;
            sum  <= '0;
        end else begin
            cout <= c[WIDTH];
            sum  <= s;
        end
    end

endmodule

// File: tb/tb_thirty_two_bit_fa.sv
// Directed and random checks of the registered 32-bit ripple-carry adder.
module tb_thirty_two_bit_fa;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cout;
    logic [31:0] sum;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cin = 1'b0;

    int tests = 0;
    int fails = 0;

    thirty_two_bit_fa dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cout  (cout),
        .sum   (sum),
        .a     (a),
        .b     (b),
        .cin   (cin)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply operands, take one rising edge, sample 1 time unit later.
    task automatic add(input logic [31:0] va, input logic [31:0] vb, input logic vc,
                       input logic [32:0] exp, input string tag);
        a = va; b = vb; cin = vc;
        @(posedge clk);
        #1;
        chk(tag, {cout, sum}, exp);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rc;
        logic [32:0] ref_v;

        // Reset asserted with operands present: outputs clear without a clock edge.
        a = 32'h12345678; b = 32'h1; cin = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk("reset_async", {cout, sum}, 33'h0);
        repeat (3) @(posedge clk);
        #1 chk("reset_hold", {cout, sum}, 33'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("release_no_edge", {cout, sum}, 33'h0);
        @(posedge clk);
        #1 chk("first_after_reset", {cout, sum}, {1'b0, 32'h12345679});

        add(32'h01111111, 32'h10010010, 1'b0, {1'b0, 32'h11121121}, "dir0");
        add(32'h0111F111, 32'h1DD10010, 1'b0, {1'b0, 32'h1EE2F121}, "dir1");
        add(32'h0FD1F111, 32'hDD1EE010, 1'b0, {1'b0, 32'hECF0D121}, "dir2");
        add(32'h0111F111, 32'h0DD10010, 1'b0, {1'b0, 32'h0EE2F121}, "dir3");
        add(32'hFFFFFFFF, 32'h00000000, 1'b1, {1'b1, 32'h00000000}, "ripple_all");
        add(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, {1'b1, 32'hFFFFFFFF}, "max_max_cin");
        add(32'h00000000, 32'h00000000, 1'b1, {1'b0, 32'h00000001}, "cin_only");
        add(32'h80000000, 32'h80000000, 1'b0, {1'b1, 32'h00000000}, "msb_carry");
        add(32'hAAAAAAAA, 32'h55555555, 1'b0, {1'b0, 32'hFFFFFFFF}, "alt_bits");

        // Outputs must hold between edges even when inputs move.
        @(negedge clk);
        a = 32'h1; b = 32'h1; cin = 1'b1;
        #1 chk("hold_between_edges", {cout, sum}, {1'b0, 32'hFFFFFFFF});

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom);
            ref_v = {1'b0, ra} + {1'b0, rb} + {32'h0, rc};
            add(ra, rb, rc, ref_v, "random");
        end

        // Mid-stream reset between edges, held across an edge, then fresh result.
        add(32'h00000010, 32'h00000020, 1'b0, {1'b0, 32'h00000030}, "pre_midreset");
        #2 rst_n = 1'b0;
        #1 chk("midreset_async", {cout, sum}, 33'h0);
        a = 32'hFFFFFFFF; b = 32'h1; cin = 1'b0;
        @(posedge clk);
        #1 chk("midreset_hold", {cout, sum}, 33'h0);
        a = 32'h00000100; b = 32'h00000200; cin = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("midreset_no_stale", {cout, sum}, 33'h0);
        @(posedge clk);
        #1 chk("midreset_first", {cout, sum}, {1'b0, 32'h00000301});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
